dmem_sequencer: RTL and testbench

Serialises SIMD load/store instructions from the control unit onto the single-port data memory shared by all PEs. On each memory instruction it latches every PE's address and store data together with the PE enable mask (top of each PE's enable stack). It then visits the enabled PEs in ascending index order, one memory access each, and returns load results per PE. It holds `busy` high so the control unit can stall the pipeline until `done`.

---
 rtl/dmem_sequencer_pkg.sv | 18 +
 rtl/dmem_sequencer_lowbit_pick.sv | 27 ++
 rtl/dmem_sequencer.sv | 157 +++++++++++++++
 tb/tb_dmem_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_sequencer_pkg.sv
// Shared definitions for the data-memory sequencer, control unit and PE.
package dmem_sequencer_pkg;

    localparam int DMEM_WIDTH = 16;
    localparam int DMEM_AW    = 16;

    // Memory opcodes the control unit decodes into start / is_store.
    localparam logic [5:0] OPload  = 6'h23;
    localparam logic [5:0] OPstore = 6'h2B;

    typedef enum logic [1:0] {
        SEQ_IDLE    = 2'd0,
        SEQ_ISSUE   = 2'd1,
        SEQ_CAPTURE = 2'd2,
        SEQ_DONE    = 2'd3
    } seq_state_t;

endpackage

// File: rtl/dmem_sequencer_lowbit_pick.sv
// Lowest-set-bit priority encoder: one-hot grant plus binary index.
module lowbit_pick #(
    parameter int NPROC = 2,
    parameter int IW    = (NPROC > 1) ? $clog2(NPROC) : 1
) (
    input  logic [NPROC-1:0] pending,
    output logic [NPROC-1:0] grant,
    output logic [IW-1:0]    idx
);

    logic found;

    // Scan upward and keep only the first set bit.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NPROC; i++) begin
            if (pending[i] && !found) begin
                grant[i] = 1'b1;
                idx      = IW'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_sequencer.sv
// Serialises SIMD loads/stores from all PEs onto the single-port data memory.
//
//  state       | meaning
//  ------------+---------------------------------------------------------
//  SEQ_IDLE    | waiting for start; inputs latched when it arrives
//  SEQ_ISSUE   | one strobe on the bus for PE sel
//  SEQ_CAPTURE | load data for PE sel arrives on mem_rdata
//  SEQ_DONE    | one-cycle done pulse, start still ignored
//
// All memory outputs are registered, so the strobe for an access is set up
// on the edge that enters ISSUE. The pick therefore works on the raw pe_en
// when leaving IDLE and on the remaining pending bits otherwise; pending is
// cleared for the chosen PE on that same edge.
module dmem_sequencer
    import dmem_sequencer_pkg::*;
#(
    parameter int NPROC = 2,
    parameter int WIDTH = DMEM_WIDTH,
    parameter int AW    = DMEM_AW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   is_store,
    input  logic [NPROC-1:0]       pe_en,
    input  logic [NPROC*AW-1:0]    pe_addr,
    input  logic [NPROC*WIDTH-1:0] pe_wdata,
    output logic [AW-1:0]          mem_addr,
    output logic [WIDTH-1:0]       mem_wdata,
    output logic                   mem_we,
    output logic                   mem_re,
    input  logic [WIDTH-1:0]       mem_rdata,
    output logic [NPROC*WIDTH-1:0] pe_rdata,
    output logic                   busy,
    output logic                   done
);

    localparam int IW = (NPROC > 1) ? $clog2(NPROC) : 1;

    seq_state_t             state;
    logic                   is_store_q;
    logic [NPROC-1:0]       pending;
    logic [NPROC*AW-1:0]    addr_q;
    logic [NPROC*WIDTH-1:0] wdata_q;
    logic [IW-1:0]          sel;

    logic [NPROC-1:0]       pick_src;
    logic [NPROC-1:0]       pick_grant;
    logic [IW-1:0]          pick_idx;
    logic [NPROC*AW-1:0]    addr_src;
    logic [NPROC*WIDTH-1:0] wdata_src;
    logic                   store_src;
    logic                   issue_next;

    lowbit_pick #(.NPROC(NPROC), .IW(IW)) u_pick (
        .pending (pick_src),
        .grant   (pick_grant),
        .idx     (pick_idx)
    );

    // Operand sources: live inputs on the accepting edge, latched copies after.
    always_comb begin
        pick_src   = pending;
        addr_src   = addr_q;
        wdata_src  = wdata_q;
        store_src  = is_store_q;
        issue_next = 1'b0;
        case (state)
            SEQ_IDLE: begin
                pick_src   = pe_en;
                addr_src   = pe_addr;
                wdata_src  = pe_wdata;
                store_src  = is_store;
                issue_next = start && (pe_en != '0);
            end
            SEQ_ISSUE:   issue_next = is_store_q && (pending != '0);
            SEQ_CAPTURE: issue_next = (pending != '0);
            default:     issue_next = 1'b0;
        endcase
    end

    // Sequencer FSM with registered strobes, status and load-result bank.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= SEQ_IDLE;
            is_store_q <= 1'b0;
            pending    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            sel        <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            pe_rdata   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;

            case (state)
                SEQ_IDLE: begin
                    if (start) begin
                        is_store_q <= is_store;
                        addr_q     <= pe_addr;
                        wdata_q    <= pe_wdata;
                        pending    <= pe_en;
                        busy       <= 1'b1;
                        if (pe_en == '0) begin
                            state <= SEQ_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                SEQ_ISSUE: begin
                    if (!is_store_q) begin
                        state <= SEQ_CAPTURE;
                    end else if (pending == '0) begin
                        state <= SEQ_DONE;
                        done  <= 1'b1;
                    end
                end
                SEQ_CAPTURE: begin
                    pe_rdata[sel*WIDTH +: WIDTH] <= mem_rdata;
                    if (pending == '0) begin
                        state <= SEQ_DONE;
                        done  <= 1'b1;
                    end
                end
                SEQ_DONE: begin
                    state <= SEQ_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= SEQ_IDLE;
            endcase

            // Any transition into ISSUE sets up the access for the lowest pending PE.
            if (issue_next) begin
                state    <= SEQ_ISSUE;
                sel      <= pick_idx;
                pending  <= pick_src & ~pick_grant;
                mem_addr <= addr_src[pick_idx*AW +: AW];
                if (store_src) begin
                    mem_we    <= 1'b1;
                    mem_wdata <= wdata_src[pick_idx*WIDTH +: WIDTH];
                end else begin
                    mem_re <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_sequencer.sv
// Self-checking bench for dmem_sequencer with a behavioural memory/lane model.
module tb_dmem_sequencer;

    localparam int NPROC = 2;
    localparam int WIDTH = 16;
    localparam int AW    = 16;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   start = 1'b0;
    logic                   is_store = 1'b0;
    logic [NPROC-1:0]       pe_en = '0;
    logic [NPROC*AW-1:0]    pe_addr = '0;
    logic [NPROC*WIDTH-1:0] pe_wdata = '0;
    logic [AW-1:0]          mem_addr;
    logic [WIDTH-1:0]       mem_wdata;
    logic                   mem_we;
    logic                   mem_re;
    logic [WIDTH-1:0]       mem_rdata = '0;
    logic [NPROC*WIDTH-1:0] pe_rdata;
    logic                   busy;
    logic                   done;

    int checks = 0;
    int errors = 0;

    logic [15:0] env_mem [logic [15:0]];
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] ref_lane [NPROC];

    dmem_sequencer #(.NPROC(NPROC), .WIDTH(WIDTH), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_store  (is_store),
        .pe_en     (pe_en),
        .pe_addr   (pe_addr),
        .pe_wdata  (pe_wdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .pe_rdata  (pe_rdata),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Unwritten locations read back a fixed address-derived pattern.
    function automatic logic [15:0] bg(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    function automatic logic [15:0] env_rd(input logic [15:0] a);
        return env_mem.exists(a) ? env_mem[a] : bg(a);
    endfunction

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : bg(a);
    endfunction

    // Single-port memory: read data one cycle after mem_re, garbage otherwise.
    always @(posedge clk) begin
        mem_rdata <= mem_re ? env_rd(mem_addr) : 16'($urandom);
        if (mem_we) env_mem[mem_addr] = mem_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] v);
        env_mem[a] = v;
        ref_mem[a] = v;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"}, busy, 1'b0);
        chk({tag, ".done"}, done, 1'b0);
        chk({tag, ".we"}, mem_we, 1'b0);
        chk({tag, ".re"}, mem_re, 1'b0);
        chk({tag, ".addr"}, mem_addr, 16'h0);
        chk({tag, ".wdata"}, mem_wdata, 16'h0);
        chk({tag, ".rdata"}, pe_rdata, 32'h0);
    endtask

    // One complete operation: model expectations, drive start, check every cycle.
    task automatic run_op(input logic st, input logic [1:0] en,
                          input logic [31:0] addrs, input logic [31:0] wd);
        int pes[$];
        int k;
        int done_c;
        logic [15:0] a [NPROC];
        logic [15:0] d [NPROC];
        logic e_we, e_re;
        logic [15:0] e_addr, e_wd;

        for (int i = 0; i < NPROC; i++) begin
            a[i] = addrs[i*16 +: 16];
            d[i] = wd[i*16 +: 16];
            if (en[i]) pes.push_back(i);
        end
        k = pes.size();
        done_c = st ? k + 1 : 2 * k + 1;

        foreach (pes[j]) begin
            if (st) ref_mem[a[pes[j]]] = d[pes[j]];
            else    ref_lane[pes[j]]  = ref_rd(a[pes[j]]);
        end

        @(negedge clk);
        start = 1'b1; is_store = st; pe_en = en; pe_addr = addrs; pe_wdata = wd;

        for (int c = 1; c <= done_c; c++) begin
            @(negedge clk);
            e_we = 1'b0; e_re = 1'b0; e_addr = 16'h0; e_wd = 16'h0;
            if (st) begin
                if (c <= k) begin
                    e_we = 1'b1; e_addr = a[pes[c-1]]; e_wd = d[pes[c-1]];
                end
            end else if (c <= 2 * k && (c % 2) == 1) begin
                e_re = 1'b1; e_addr = a[pes[(c-1)/2]];
            end
            chk("busy", busy, 1'b1);
            chk("done", done, (c == done_c));
            chk("mem_we", mem_we, e_we);
            chk("mem_re", mem_re, e_re);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wd);
            if (c == done_c)
                for (int i = 0; i < NPROC; i++)
                    chk("pe_rdata", pe_rdata[i*16 +: 16], ref_lane[i]);
            // Ignored start attempts and mid-operation input churn.
            start = 1'($urandom_range(0, 1));
            is_store = 1'($urandom); pe_en = 2'($urandom);
            pe_addr = $urandom; pe_wdata = $urandom;
        end

        @(negedge clk);
        start = 1'b0;
        chk("idle.busy", busy, 1'b0);
        chk("idle.done", done, 1'b0);
        chk("idle.we", mem_we, 1'b0);
        chk("idle.re", mem_re, 1'b0);
        if (st)
            foreach (pes[j])
                chk("mem_content", env_rd(a[pes[j]]), ref_rd(a[pes[j]]));
    endtask

    initial begin
        for (int i = 0; i < NPROC; i++) ref_lane[i] = 16'h0;

        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Two-PE store
        run_op(1'b1, 2'b11, {16'h0011, 16'h0010}, {16'h5555, 16'hAAAA});
        chk("st.m10", env_rd(16'h0010), 16'hAAAA);
        chk("st.m11", env_rd(16'h0011), 16'h5555);

        // Two-PE load
        preload(16'h0020, 16'h1234);
        preload(16'h0021, 16'hBEEF);
        run_op(1'b0, 2'b11, {16'h0021, 16'h0020}, 32'h0);
        chk("ld.lanes", pe_rdata, 32'hBEEF_1234);

        // Disabled PE keeps its lane
        preload(16'h0030, 16'h7777);
        preload(16'h0031, 16'h9999);
        run_op(1'b0, 2'b01, {16'h0031, 16'h0030}, 32'h0);
        run_op(1'b0, 2'b10, {16'h0031, 16'h0030}, 32'h0);
        chk("ld.lane0_kept", pe_rdata[15:0], 16'h7777);
        chk("ld.lane1", pe_rdata[31:16], 16'h9999);

        // Empty mask, both directions
        run_op(1'b1, 2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
        run_op(1'b0, 2'b00, 32'h1234_5678, 32'h9ABC_DEF0);

        // Same-address store: highest PE wins
        run_op(1'b1, 2'b11, {16'h0040, 16'h0040}, {16'h0002, 16'h0001});
        chk("same_addr", env_rd(16'h0040), 16'h0002);

        // Reset in cycle 2 of a load aborts it
        preload(16'h0050, 16'h0A0A);
        preload(16'h0051, 16'h0B0B);
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; pe_en = 2'b11; pe_addr = {16'h0051, 16'h0050};
        @(negedge clk);
        start = 1'b0;
        chk("abort.c1_re", mem_re, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_all_zero("abort");
        for (int i = 0; i < NPROC; i++) ref_lane[i] = 16'h0;
        repeat (3) begin
            @(negedge clk);
            chk_all_zero("held");
        end
        reset = 1'b1;
        run_op(1'b0, 2'b11, {16'h0051, 16'h0050}, 32'h0);
        chk("post_reset.lanes", pe_rdata, 32'h0B0B_0A0A);

        // Randomised mix over a small address window to force collisions
        for (int n = 0; n < 40; n++) begin
            logic [31:0] ra;
            ra = {16'h0100 + 16'($urandom_range(0, 7)), 16'h0100 + 16'($urandom_range(0, 7))};
            run_op(1'($urandom), 2'($urandom), ra, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
